// File: rtl/pad_scan_pkg.sv
// Shared types and defaults for the pad/tile-sensor scan controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: scan FSM state enum, default parameter values and a helper that
// returns the frame period in PCLK cycles for a given configuration.
package pad_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        LATCH_HI,
        SHIFT_LO,
        SHIFT_HI,
        PUBLISH,
        GAP
    } scan_state_t;

    localparam int DEF_NUM_CH   = 6;
    localparam int DEF_NUM_BITS = 8;
    localparam int DEF_CLK_DIV  = 50;
    localparam int DEF_SCAN_GAP = 1000;

    // Cycles from one PUBLISH to the next while scanning continuously.
    function automatic int frame_cycles(input int num_ch, input int num_bits,
                                        input int clk_div, input int scan_gap);
        return num_ch * (2 * num_bits + 1) * clk_div + 1 + scan_gap;
    endfunction

endpackage

// File: rtl/pad_scan_tick.sv
// Prescaler producing one tick (terminal count) every CLK_DIV cycles.
// Latency: tick is combinational from the counter; restart takes effect next cycle.
// Backpressure: none; restart re-aligns the count to zero.
//
// Ports: clk, rst (sync, active-high), restart (sync clear), tick (counter == CLK_DIV-1).
module pad_scan_tick
    import pad_scan_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pad_scan_ctrl.sv
// Scans NUM_CH serial pad shift registers over a shared latch/clock/data bus and publishes a coherent snapshot per frame.
// Latency: one frame = NUM_CH*(2*NUM_BITS+1)*CLK_DIV + 1 + SCAN_GAP cycles; pad_state/FABINT update the cycle after frame_done.
// Backpressure: none; enable low aborts the frame next cycle, FABINT held until int_clear.
//
// Ports: PCLK/PRESET (sync, active-high); enable, data (active-low), int_clear in;
//        sr_reset, latch, clock, selection (one-hot), pad_state, frame_done, FABINT out.
// Build option: define PAD_SCAN_DEBOUNCE_EN to require two agreeing frames before a pad_state bit changes.
module pad_scan_ctrl
    import pad_scan_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int NUM_BITS = DEF_NUM_BITS,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int SCAN_GAP = DEF_SCAN_GAP
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         enable,
    input  logic                         data,
    input  logic                         int_clear,
    output logic                         sr_reset,
    output logic                         latch,
    output logic                         clock,
    output logic [NUM_CH-1:0]            selection,
    output logic [NUM_CH*NUM_BITS-1:0]   pad_state,
    output logic                         frame_done,
    output logic                         FABINT
);

    localparam int W   = NUM_CH * NUM_BITS;
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BW  = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int IW  = $clog2(W + 1);
    localparam int GW  = $clog2(SCAN_GAP + 1);

    scan_state_t       state, state_nxt;
    logic              tick;
    logic              restart;
    logic [CHW-1:0]    ch_idx;
    logic [BW-1:0]     bit_idx;
    logic [GW-1:0]     gap_cnt;
    logic [W-1:0]      shadow;
    logic [W-1:0]      pad_next;
    logic [NUM_CH-1:0] sel_onehot;
    logic [IW-1:0]     sh_idx;
    logic              ch_last, bit_last, gap_done;
    logic              publish, fab_set;

    assign sel_onehot = NUM_CH'(1) << ch_idx;
    assign ch_last    = (ch_idx == CHW'(NUM_CH - 1));
    assign bit_last   = (bit_idx == BW'(NUM_BITS - 1));
    assign gap_done   = (gap_cnt == GW'(SCAN_GAP - 1));
    assign sh_idx     = IW'(ch_idx) * IW'(NUM_BITS) + IW'(bit_idx);

    // Every state lasts whole ticks measured from its entry; in IDLE the
    // count is also held at zero until enable rises so the sr_reset
    // extension is exactly one tick long.
    assign restart = (state_nxt != state) || (state == IDLE && !enable);

    pad_scan_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (PCLK),
        .rst     (PRESET),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sr_reset   = 1'b0;
        latch      = 1'b0;
        clock      = 1'b0;
        selection  = '0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                sr_reset = 1'b1;
                if (enable && tick) state_nxt = SELECT;
            end
            SELECT: begin
                selection = sel_onehot;
                if (!enable)   state_nxt = IDLE;
                else if (tick) state_nxt = LATCH_HI;
            end
            LATCH_HI: begin
                selection = sel_onehot;
                latch     = 1'b1;
                if (!enable)   state_nxt = IDLE;
                else if (tick) state_nxt = SHIFT_LO;
            end
            SHIFT_LO: begin
                selection = sel_onehot;
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (!bit_last)    state_nxt = SHIFT_HI;
                    else if (ch_last) state_nxt = PUBLISH;
                    else              state_nxt = SELECT;
                end
            end
            SHIFT_HI: begin
                selection = sel_onehot;
                clock     = 1'b1;
                if (!enable)   state_nxt = IDLE;
                else if (tick) state_nxt = SHIFT_LO;
            end
            PUBLISH: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else begin
                    frame_done = 1'b1;
                    state_nxt  = GAP;
                end
            end
            GAP: begin
                if (!enable)       state_nxt = IDLE;
                else if (gap_done) state_nxt = SELECT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign publish = (state == PUBLISH) && enable;

`ifdef PAD_SCAN_DEBOUNCE_EN
    // Raw sample of the last published frame; a bit only moves when the
    // current and previous raw frames agree on it.
    logic [W-1:0] prev_raw;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            prev_raw <= '0;
        end else if (publish) begin
            prev_raw <= shadow;
        end
    end

    assign pad_next = (~(shadow ^ prev_raw) & shadow) | ((shadow ^ prev_raw) & pad_state);
`else
    assign pad_next = shadow;
`endif

    assign fab_set = publish && (pad_next != pad_state);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ch_idx    <= '0;
            bit_idx   <= '0;
            gap_cnt   <= '0;
            shadow    <= '0;
            pad_state <= '0;
            FABINT    <= 1'b0;
        end else begin
            // Leaving for IDLE (abort or idle hold) discards the partial frame.
            if (state_nxt == IDLE) begin
                ch_idx  <= '0;
                bit_idx <= '0;
                shadow  <= '0;
            end else begin
                if (state == GAP && state_nxt == SELECT) begin
                    ch_idx <= '0;
                end else if (state == SHIFT_LO && state_nxt == SELECT) begin
                    ch_idx <= ch_idx + CHW'(1);
                end

                if (state == LATCH_HI) begin
                    bit_idx <= '0;
                end else if (state == SHIFT_HI && state_nxt == SHIFT_LO) begin
                    bit_idx <= bit_idx + BW'(1);
                end

                // Pads are active-low; store 1 = pressed.
                if (state == SHIFT_LO && tick) begin
                    shadow[sh_idx] <= ~data;
                end
            end

            if (state == GAP) begin
                gap_cnt <= gap_cnt + GW'(1);
            end else begin
                gap_cnt <= '0;
            end

            if (publish) begin
                pad_state <= pad_next;
            end

            // A fresh change outranks a coincident clear.
            if (fab_set) begin
                FABINT <= 1'b1;
            end else if (int_clear) begin
                FABINT <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pad_scan_ctrl.sv
// Testbench for pad_scan_ctrl: pad shift-register model, expectation queue, frame monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_pad_scan_ctrl;

    localparam int NCH    = 6;
    localparam int NB     = 8;
    localparam int PERIOD = 209;   // 6*17*2 + 1 + 4

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        enable;
    logic        int_clear;
    wire         data;
    logic        sr_reset, latch, clock, frame_done, FABINT;
    logic [5:0]  selection;
    logic [47:0] pad_state;

    pad_scan_ctrl #(.NUM_CH(NCH), .NUM_BITS(NB), .CLK_DIV(2), .SCAN_GAP(4)) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .enable     (enable),
        .data       (data),
        .int_clear  (int_clear),
        .sr_reset   (sr_reset),
        .latch      (latch),
        .clock      (clock),
        .selection  (selection),
        .pad_state  (pad_state),
        .frame_done (frame_done),
        .FABINT     (FABINT)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [47:0] pad;
        logic        fab;
        bit          per;
    } exp_t;

    exp_t        q[$];
    exp_t        e_mon;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    int          last_done = 0;
    logic [47:0] m_pad, m_prev;
    logic        m_fab;
    logic [7:0]  press [NCH];

    // Pad model: parallel load on latch (active-low outputs), shift on clock rise.
    logic [7:0] sreg  = 8'hFF;
    logic       clk_q = 1'b0;
    assign data = sreg[0];

    always @(posedge PCLK) begin
        if (latch === 1'b1) begin
            for (int c = 0; c < NCH; c++)
                if (selection[c] === 1'b1) sreg <= ~press[c];
        end else if (clock === 1'b1 && clk_q === 1'b0) begin
            sreg <= {1'b1, sreg[7:1]};
        end
        clk_q <= clock;
    end

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    function automatic logic [47:0] raw_of();
        logic [47:0] r;
        for (int c = 0; c < NCH; c++) r[c*NB +: NB] = press[c];
        return r;
    endfunction

    // Queue the expected outcome of the next frame scanned with the current press pattern.
    task automatic expect_frame(input bit clr_same, input bit per);
        logic [47:0] raw, nv;
        exp_t e;
        raw = raw_of();
`ifdef PAD_SCAN_DEBOUNCE_EN
        for (int i = 0; i < 48; i++) nv[i] = (raw[i] == m_prev[i]) ? raw[i] : m_pad[i];
        m_prev = raw;
`else
        nv = raw;
`endif
        if (nv != m_pad) m_fab = 1'b1;
        else if (clr_same) m_fab = 1'b0;
        m_pad = nv;
        e.pad = nv;
        e.fab = m_fab;
        e.per = per;
        q.push_back(e);
    endtask

    task automatic wait_frame();
        int n = 0;
        @(negedge PCLK);
        while (frame_done !== 1'b1 && n < 2000) begin
            @(negedge PCLK);
            n++;
        end
        if (frame_done !== 1'b1) check("frame_timeout", 0, 1);
    endtask

    task automatic clear_gap();
        @(negedge PCLK) int_clear = 1'b1;
        @(negedge PCLK) int_clear = 1'b0;
        m_fab = 1'b0;
        check("FABINT_cleared", FABINT, 0);
    endtask

    // Monitor: every frame_done is matched against the oldest expectation.
    always @(negedge PCLK) begin
        if (PRESET === 1'b0 && frame_done === 1'b1) begin
            done_cnt++;
            if (q.size() == 0) begin
                check("unexpected_frame_done", 1, 0);
                last_done = cyc;
            end else begin
                e_mon = q.pop_front();
                if (e_mon.per) check("frame_period", cyc - last_done, PERIOD);
                last_done = cyc;
                @(posedge PCLK);
                #1;
                check("pad_state", pad_state, e_mon.pad);
                check("FABINT", FABINT, e_mon.fab);
            end
        end
    end

    initial begin
        int n, dwell, lat, d0;
        logic [5:0] want;

        PRESET = 1'b1; enable = 1'b0; int_clear = 1'b0;
        for (int c = 0; c < NCH; c++) press[c] = 8'h00;
        m_pad = '0; m_prev = '0; m_fab = 1'b0;

        repeat (5) @(negedge PCLK);
        check("rst_sr_reset", sr_reset, 1);
        check("rst_selection", selection, 0);
        check("rst_latch", latch, 0);
        check("rst_clock", clock, 0);
        check("rst_pad_state", pad_state, 0);
        check("rst_FABINT", FABINT, 0);
        check("rst_frame_done", frame_done, 0);

        PRESET = 1'b0;
        repeat (3) @(negedge PCLK);
        check("idle_sr_reset", sr_reset, 1);

        // Frame 1: walk the one-hot select, 34 cycles per channel, one latch tick each.
        enable = 1'b1;
        expect_frame(1'b0, 1'b0);
        for (int c = 0; c < NCH; c++) begin
            want = 6'b000001 << c;
            n = 0;
            while (selection !== want && n < 300) begin
                @(negedge PCLK);
                n++;
            end
            dwell = 0; lat = 0;
            while (selection === want && dwell < 300) begin
                dwell++;
                if (latch === 1'b1) lat++;
                @(negedge PCLK);
            end
            check("channel_dwell", dwell, 34);
            check("latch_cycles", lat, 2);
        end
        check("sel_zero_after_ch5", selection, 0);

        // Frame 2: all released, period check.
        expect_frame(1'b0, 1'b1);
        wait_frame();

        // Frame 3: channel 2 bit 3 pressed -> pad_state[19].
        press[2] = 8'h08;
        expect_frame(1'b0, 1'b1);
        wait_frame();
        clear_gap();

        // Frame 4: identical -> no new set.
        expect_frame(1'b0, 1'b1);
        wait_frame();

        // Frame 5: add channel 5 pattern.
        press[5] = 8'h81;
        expect_frame(1'b0, 1'b1);
        wait_frame();

        // Frame 6: change coincides with int_clear in PUBLISH -> set wins.
        press[2] = 8'h00;
        expect_frame(1'b1, 1'b1);
        wait_frame();
        int_clear = 1'b1;
        @(negedge PCLK) int_clear = 1'b0;
        clear_gap();

        // Abort during channel 3 SHIFT_HI.
        press[3] = 8'hFF;
        n = 0;
        while (!(selection === 6'b001000 && clock === 1'b1) && n < 400) begin
            @(negedge PCLK);
            n++;
        end
        check("reached_ch3_shift_hi", {selection, clock}, {6'b001000, 1'b1});
        enable = 1'b0;
        @(posedge PCLK);
        #1;
        check("abort_selection", selection, 0);
        check("abort_clock", clock, 0);
        check("abort_latch", latch, 0);
        check("abort_sr_reset", sr_reset, 1);
        d0 = done_cnt;
        repeat (300) @(negedge PCLK);
        check("abort_no_frame_done", done_cnt, d0);
        check("abort_pad_state", pad_state, m_pad);
        check("abort_FABINT", FABINT, m_fab);

        // Re-enable: a full frame with channel 3 all pressed.
        enable = 1'b1;
        expect_frame(1'b0, 1'b0);
        wait_frame();

`ifdef PAD_SCAN_DEBOUNCE_EN
        press[0] = 8'h01;
        expect_frame(1'b0, 1'b1);
        wait_frame();
        @(posedge PCLK); #1;
        check("deb_one_frame", pad_state[0], 0);
        press[0] = 8'h00;
        expect_frame(1'b0, 1'b1);
        wait_frame();
        press[0] = 8'h01;
        expect_frame(1'b0, 1'b1);
        wait_frame();
        @(posedge PCLK); #1;
        check("deb_first_of_two", pad_state[0], 0);
        expect_frame(1'b0, 1'b1);
        wait_frame();
        @(posedge PCLK); #1;
        check("deb_second_of_two", pad_state[0], 1);
`endif

        // Reset mid-frame clears everything.
        check("queue_drained", q.size(), 0);
        repeat (50) @(negedge PCLK);
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        check("midrst_pad_state", pad_state, 0);
        check("midrst_FABINT", FABINT, 0);
        check("midrst_sr_reset", sr_reset, 1);
        check("midrst_selection", selection, 0);
        PRESET = 1'b0;
        repeat (5) @(negedge PCLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
